// File: rtl/stream_multicast_seq.sv
// Serialising multicast scheduler: one input beat is offered to each selected output in turn.
// Optional round-robin start position across beats: define COMMON_CELLS_MCAST_RR_EN.
module stream_multicast_seq #(
  parameter int unsigned N_OUP    = 2,
  parameter int unsigned IdxWidth = (N_OUP > 1) ? $clog2(N_OUP) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic [N_OUP-1:0]    sel_i,
  output logic [N_OUP-1:0]    valid_o,
  input  logic [N_OUP-1:0]    ready_i,
  output logic [IdxWidth-1:0] idx_o,
  output logic                busy_o
);

  typedef enum logic {IDLE, SEND} state_e;

  state_e              r_state;
  logic [N_OUP-1:0]    r_pend;
  logic [N_OUP-1:0]    w_cand;
  logic [N_OUP-1:0]    w_onehot;
  logic [N_OUP-1:0]    w_rest;
  logic [IdxWidth-1:0] w_k;
  logic [IdxWidth-1:0] w_start;
  logic                w_found;
  logic                w_hs;
  logic                w_last;
  int unsigned         w_j;

`ifdef COMMON_CELLS_MCAST_RR_EN
  logic [IdxWidth-1:0] r_ptr;
  logic [IdxWidth-1:0] w_next;
  assign w_start = r_ptr;
  assign w_next  = (32'(w_k) == N_OUP - 1) ? '0 : w_k + IdxWidth'(1);
`else
  assign w_start = '0;
`endif

  // Wrap-around priority scan from w_start over the candidate mask.
  always_comb begin
    w_cand   = (r_state == SEND) ? r_pend : (valid_i ? sel_i : '0);
    w_found  = 1'b0;
    w_k      = '0;
    w_j      = 0;
    w_onehot = '0;
    for (int unsigned i = 0; i < N_OUP; i++) begin
      w_j = 32'(w_start) + i;
      if (w_j >= N_OUP) w_j = w_j - N_OUP;
      if (!w_found && w_cand[w_j[IdxWidth-1:0]]) begin
        w_found = 1'b1;
        w_k     = w_j[IdxWidth-1:0];
      end
    end
    if (w_found) w_onehot[w_k] = 1'b1;
  end

  assign w_rest  = w_cand & ~w_onehot;
  assign w_hs    = w_found && ready_i[w_k];
  assign w_last  = w_hs && (w_rest == '0);

  assign valid_o = w_onehot;
  assign idx_o   = w_k;
  assign busy_o  = (r_state == SEND);
  assign ready_o = (r_state == IDLE) ? (valid_i && ((sel_i == '0) || w_last)) : w_last;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_pend  <= '0;
    end else if (w_hs) begin
      if (w_rest == '0) begin
        r_state <= IDLE;
        r_pend  <= '0;
      end else begin
        r_state <= SEND;
        r_pend  <= w_rest;
      end
    end else if ((r_state == IDLE) && w_found) begin
      r_state <= SEND;
      r_pend  <= sel_i;
    end
  end

`ifdef COMMON_CELLS_MCAST_RR_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr <= '0;
    end else if (w_last) begin
      r_ptr <= w_next;
    end
  end
`endif

`ifndef SYNTHESIS
  a_send_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (r_state == SEND) |-> (valid_i && $stable(sel_i)))
    else $error("stream_multicast_seq: valid_i/sel_i changed while beat in progress");
`endif

endmodule
